// File: rtl/mirror_skolem_checker.sv
// mirror_skolem_checker
//
// Exhaustive checker for a Skolem-function DUT that is expected to mirror its
// universal inputs: for every x in [0, 2^N) the DUT must answer y == x.
// Each vector is sent over a valid/ready request channel. The response comes
// back on a valid-only channel. The checker counts mismatching vectors and
// keeps the first one.
//
// Handshake rule: a request transfers on a rising edge where x_valid and
// x_ready are both 1. While x_valid is 1 and x_ready is 0, x_o holds its
// value. Only one request is outstanding at a time, so x_valid is 0 in WAIT.
// The response is taken on any edge in WAIT where y_valid is 1. If y_valid
// is 1 in any other state, protocol_err is set and the response is dropped.
//
// Optional feature: define MIRROR_CHK_STOP_ON_FAIL_EN to end the check at the
// first mismatching vector. By default all 2^N vectors are enumerated.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   start            one-cycle pulse that begins a check (ignored while busy)
//   x_o, x_valid     request to the DUT (x_o[k] drives DUT input i<k>)
//   x_ready          DUT accepts the request
//   y_i, y_valid     DUT response (y_i[k] is DUT output i<N+k>)
//   busy             check in progress (SEND or WAIT)
//   done, pass       check finished; pass is valid only while done=1
//   fail_count       number of mismatching vectors (saturating)
//   first_fail_x     x of the first mismatching vector
//   first_fail_diff  y_i ^ x of the first mismatching vector
//   protocol_err     sticky: y_valid was seen outside WAIT
//   dbg_state        current FSM state (0 IDLE, 1 SEND, 2 WAIT, 3 DONE)
module mirror_skolem_checker #(
    parameter int N  = 20,
    parameter int CW = 21
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic [N-1:0]  x_o,
    output logic          x_valid,
    input  logic          x_ready,
    input  logic [N-1:0]  y_i,
    input  logic          y_valid,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [CW-1:0] fail_count,
    output logic [N-1:0]  first_fail_x,
    output logic [N-1:0]  first_fail_diff,
    output logic          protocol_err,
    output logic [1:0]    dbg_state
);

    // The counter must be able to hold 2^N mismatches.
    if (CW < N + 1) begin : g_bad_cw
        $error("mirror_skolem_checker: CW must be at least N+1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    cnt_q;
    logic [CW-1:0]   fail_q;
    logic [N-1:0]    ffx_q;
    logic [N-1:0]    ffd_q;
    logic            perr_q;

    logic            start_ok;
    logic            compare;
    logic [N-1:0]    diff;
    logic            mism;
    logic            last;
    logic            stop_hit;

    assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));
    assign compare  = (state_q == WAIT) && y_valid;
    // The vector counter does not change between acceptance and the response,
    // so it also serves as the latched x for the compare.
    assign diff     = y_i ^ cnt_q;
    assign mism     = |diff;
    assign last     = (cnt_q == {N{1'b1}});

`ifdef MIRROR_CHK_STOP_ON_FAIL_EN
    assign stop_hit = mism;
`else
    assign stop_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SEND;
            SEND:    if (x_ready) state_d = WAIT;
            WAIT:    if (y_valid) state_d = (last || stop_hit) ? DONE : SEND;
            DONE:    if (start) state_d = SEND;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        x_valid   = (state_q == SEND);
        busy      = (state_q == SEND) || (state_q == WAIT);
        done      = (state_q == DONE);
        pass      = (state_q == DONE) && (fail_q == '0) && !perr_q;
        dbg_state = state_q;
    end

    // Vector counter, result registers and the protocol flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            fail_q <= '0;
            ffx_q  <= '0;
            ffd_q  <= '0;
            perr_q <= 1'b0;
        end else if (start_ok) begin
            cnt_q  <= '0;
            fail_q <= '0;
            ffx_q  <= '0;
            ffd_q  <= '0;
            perr_q <= 1'b0;
        end else begin
            if (y_valid && (state_q != WAIT)) begin
                perr_q <= 1'b1;
            end
            if (compare) begin
                if (mism) begin
                    // fail_q is still zero only until the first mismatch,
                    // because it saturates and never wraps.
                    if (fail_q == '0) begin
                        ffx_q <= cnt_q;
                        ffd_q <= diff;
                    end
                    if (fail_q != {CW{1'b1}}) begin
                        fail_q <= fail_q + 1'b1;
                    end
                end
                if (state_d == SEND) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign x_o             = cnt_q;
    assign fail_count      = fail_q;
    assign first_fail_x    = ffx_q;
    assign first_fail_diff = ffd_q;
    assign protocol_err    = perr_q;

endmodule

// File: tb/tb_mirror_skolem_checker.sv
// Bench for mirror_skolem_checker, built with N=4 and CW=5.
// A responder process stands in for the Skolem DUT. It drives x_ready and
// y_i/y_valid on falling edges. It can apply fault and stall modes, and it
// can inject stray y_valid pulses.
module tb_mirror_skolem_checker;
    localparam int N  = 4;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          x_ready = 1'b0;
    logic [N-1:0]  y_i = '0;
    logic          y_valid = 1'b0;
    logic [N-1:0]  x_o;
    logic          x_valid;
    logic          busy;
    logic          done;
    logic          pass;
    logic [CW-1:0] fail_count;
    logic [N-1:0]  first_fail_x;
    logic [N-1:0]  first_fail_diff;
    logic          protocol_err;
    logic [1:0]    dbg_state;

    mirror_skolem_checker #(.N(N), .CW(CW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .x_o             (x_o),
        .x_valid         (x_valid),
        .x_ready         (x_ready),
        .y_i             (y_i),
        .y_valid         (y_valid),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .fail_count      (fail_count),
        .first_fail_x    (first_fail_x),
        .first_fail_diff (first_fail_diff),
        .protocol_err    (protocol_err),
        .dbg_state       (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Checking
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Responder state and scoreboard
    int           rand_mode  = 0;
    int           fault_mode = 0;
    int           spur_req   = 0;  // 1: fire while x_valid, 2: fire now
    int           lat_cnt    = 0;
    int           stall_bad  = 0;
    int           sb_extra   = 0;
    logic         hs_armed   = 1'b0;
    logic [N-1:0] hs_x       = '0;
    logic [N-1:0] held_x     = '0;
    logic         prev_xv    = 1'b0;
    logic         prev_xr    = 1'b0;
    logic [N-1:0] prev_x     = '0;
    logic [N-1:0] exp_q[$];

    // Mirror DUT model; the fault version has y[2] stuck at 0.
    function automatic logic [N-1:0] model(input logic [N-1:0] x, input int f);
        logic [N-1:0] m;
        m = 4'b1011;
        return (f != 0) ? (x & m) : x;
    endfunction

    always @(negedge clk) begin
        int lat;
        if (!rst_n) begin
            y_valid  = 1'b0;
            x_ready  = 1'b0;
            lat_cnt  = 0;
            hs_armed = 1'b0;
            prev_xv  = 1'b0;
            prev_xr  = 1'b0;
            exp_q.delete();
        end else begin
            y_valid = 1'b0;
            // x_o must not change while a request is stalled.
            if (prev_xv && !prev_xr && x_valid && (x_o !== prev_x)) stall_bad++;
            if (lat_cnt > 0) begin
                lat_cnt--;
                if (lat_cnt == 0) begin
                    y_valid = 1'b1;
                    y_i     = model(held_x, fault_mode);
                end
            end
            if (hs_armed) begin
                held_x = hs_x;
                if (exp_q.size() == 0) sb_extra++;
                else check("x_seq", hs_x, exp_q.pop_front());
                lat = (rand_mode != 0) ? $urandom_range(1, 5) : 1;
                if (lat == 1) begin
                    y_valid = 1'b1;
                    y_i     = model(held_x, fault_mode);
                end else begin
                    lat_cnt = lat - 1;
                end
            end
            if ((spur_req == 2) || ((spur_req == 1) && x_valid)) begin
                y_valid  = 1'b1;
                y_i      = 4'hf;
                spur_req = 0;
            end
            x_ready  = (rand_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            hs_armed = x_valid && x_ready;
            hs_x     = x_o;
            prev_xv  = x_valid;
            prev_xr  = x_ready;
            prev_x   = x_o;
        end
    end

    task automatic fill_exp();
        exp_q.delete();
        for (int v = 0; v < 16; v++) exp_q.push_back(4'(v));
        sb_extra  = 0;
        stall_bad = 0;
    endtask

    // Pulse start and count cycles until done. perr1 is protocol_err one
    // cycle after start was sampled.
    task automatic run_check(output int cyc, output logic perr1);
        fill_exp();
        perr1 = 1'b1;
        @(negedge clk);
        start = 1'b1;
        cyc   = 0;
        while (1) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            cyc++;
            if (cyc == 1) perr1 = protocol_err;
            if (done) break;
            if (cyc > 3000) begin
                check("done_timeout", done, 1);
                break;
            end
        end
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_x_o"},     x_o, 0);
        check({pfx, "_x_valid"}, x_valid, 0);
        check({pfx, "_busy"},    busy, 0);
        check({pfx, "_done"},    done, 0);
        check({pfx, "_pass"},    pass, 0);
        check({pfx, "_fail"},    fail_count, 0);
        check({pfx, "_ffx"},     first_fail_x, 0);
        check({pfx, "_ffd"},     first_fail_diff, 0);
        check({pfx, "_perr"},    protocol_err, 0);
        check({pfx, "_state"},   dbg_state, 0);
    endtask

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc;
        logic perr1;
        bit   seen;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("rst");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Ideal mirror, no stalls
        rand_mode = 0; fault_mode = 0;
        run_check(cyc, perr1);
        check("ideal_cycles", cyc, 33);
        check("ideal_pass", pass, 1);
        check("ideal_fail", fail_count, 0);
        check("ideal_busy", busy, 0);
        check("ideal_perr", protocol_err, 0);
        check("ideal_left", exp_q.size(), 0);
        check("ideal_extra", sb_extra, 0);
        repeat (3) @(negedge clk);
        check("ideal_done_held", done, 1);

        // y[2] stuck at 0
        fault_mode = 1;
        run_check(cyc, perr1);
`ifdef MIRROR_CHK_STOP_ON_FAIL_EN
        check("fault_cycles", cyc, 11);
        check("fault_fail", fail_count, 1);
        check("fault_left", exp_q.size(), 11);
`else
        check("fault_cycles", cyc, 33);
        check("fault_fail", fail_count, 8);
        check("fault_left", exp_q.size(), 0);
`endif
        check("fault_ffx", first_fail_x, 4'b0100);
        check("fault_ffd", first_fail_diff, 4'b0100);
        check("fault_pass", pass, 0);
        check("fault_done", done, 1);

        // Random stalls and response latencies
        fault_mode = 0; rand_mode = 1;
        run_check(cyc, perr1);
        check("rand_pass", pass, 1);
        check("rand_fail", fail_count, 0);
        check("rand_stall", stall_bad, 0);
        check("rand_left", exp_q.size(), 0);
        check("rand_extra", sb_extra, 0);
        rand_mode = 0;

        // Asynchronous reset in the middle of a check
        fault_mode = 1;
        fill_exp();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (x_valid && (x_o == 4'd7)) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("v7_reached", seen, 1);
        check("pre_rst_fail", fail_count, 3);
        check("pre_rst_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("arst");
        @(negedge clk); rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("no_resume_busy", busy, 0);
        check("no_resume_xv", x_valid, 0);
        check("no_resume_done", done, 0);

        // Stray y_valid in IDLE, then a clean check
        fault_mode = 0;
        spur_req = 2;
        repeat (3) @(negedge clk);
        check("idle_spur_perr", protocol_err, 1);
        run_check(cyc, perr1);
        check("start_clr_perr", perr1, 0);
        check("post_rst_pass", pass, 1);
        check("post_rst_cycles", cyc, 33);

        // Stray y_valid while a request is being sent
        spur_req = 1;
        run_check(cyc, perr1);
        check("send_spur_perr", protocol_err, 1);
        check("send_spur_pass", pass, 0);
        check("send_spur_done", done, 1);
        check("send_spur_fail", fail_count, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mirror_skolem_checker.md
MIRROR_SKOLEM_CHECKER -- requirements
Module: mirror_skolem_checker

Interface
REQ-001 SHALL have parameter N, default 20: number of universal inputs, equal to the number of Skolem outputs.
REQ-002 SHALL have parameter CW, default 21: width of the fail counter; CW SHALL be at least N+1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: a single-cycle pulse that begins an exhaustive check.
REQ-006 SHALL have port x_o, output, N bits: input assignment driven to the Skolem DUT (x_o[k] feeds i<k>).
REQ-007 SHALL have port x_valid, output, 1 bit: x_o is valid.
REQ-008 SHALL have port x_ready, input, 1 bit: the DUT accepts x_o.
REQ-009 SHALL have port y_i, input, N bits: DUT outputs (y_i[k] is i<N+k>).
REQ-010 SHALL have port y_valid, input, 1 bit: y_i is valid.
REQ-011 SHALL have port busy, output, 1 bit: a check is in progress.
REQ-012 SHALL have port done, output, 1 bit: the check has completed; held until the next start.
REQ-013 SHALL have port pass, output, 1 bit: the check completed with zero mismatches; valid only while done=1.
REQ-014 SHALL have port fail_count, output, CW bits: number of mismatching vectors.
REQ-015 SHALL have port first_fail_x, output, N bits: x of the first mismatching vector.
REQ-016 SHALL have port first_fail_diff, output, N bits: y_i XOR x for the first mismatch.
REQ-017 SHALL have port protocol_err, output, 1 bit: sticky flag set when y_valid arrives outside the WAIT state.

Function
REQ-018 SHALL implement the FSM states IDLE, SEND, WAIT, DONE.
REQ-019 SHALL, on start in IDLE or DONE, clear the vector counter, fail_count, first_fail_*, pass and protocol_err, and go to SEND the next cycle.
REQ-020 SHALL, in SEND, drive x_valid=1 with x_o = counter; on x_valid&x_ready, latch x_o and go to WAIT.
REQ-021 SHALL keep x_o stable while x_valid=1 and x_ready=0.
REQ-022 SHALL allow only one transaction outstanding at a time; x_valid SHALL be 0 in WAIT.
REQ-023 SHALL, in WAIT, on y_valid compare y_i with the latched x under the mirror relation (y[k]==x[k] for all k); a mismatch is any bit set in y_i XOR x.
REQ-024 SHALL, on a mismatch, increment fail_count (saturating at all-ones); if this is the first mismatch, capture first_fail_x and first_fail_diff.
REQ-025 SHALL, after the compare, go to DONE if the counter equals 2^N-1, else increment the counter (mod 2^N) and go to SEND.
REQ-026 SHALL be able to accept a new transaction in the cycle after y_valid, giving a minimum of 2 cycles per vector.
REQ-027 SHALL, in DONE, assert done=1 and set pass = (fail_count==0 and protocol_err==0).
REQ-028 SHALL drive busy=1 in SEND and WAIT.
REQ-029 SHALL ignore start while busy.
REQ-030 SHALL, for y_valid in IDLE, SEND or DONE, set protocol_err and discard the data.

Reset
REQ-031 SHALL, on rst_n=0 at any time including mid-check, immediately place the FSM in IDLE and zero x_o, x_valid, busy, done, pass, fail_count, first_fail_x, first_fail_diff, protocol_err and the vector counter.
REQ-032 SHALL not resume an aborted check after reset release; a new start is required.

Configuration
REQ-033 SHALL, with macro MIRROR_CHK_STOP_ON_FAIL_EN defined, go from WAIT to DONE immediately after the first mismatch; in that case fail_count=1 and pass=0.
REQ-034 SHALL, with MIRROR_CHK_STOP_ON_FAIL_EN undefined, enumerate all 2^N vectors regardless of mismatches.

Verification (run with N=4 unless noted)
REQ-035 SHALL cover: ideal mirror DUT, x_ready=1, 1-cycle y_valid -> done after 16 vectors, pass=1, fail_count=0, start-to-done 33 cycles.
REQ-036 SHALL cover: DUT with y[2] stuck at 0 -> fail_count=8, first_fail_x=4'b0100, first_fail_diff=4'b0100, pass=0.
REQ-037 SHALL cover: random x_ready stalls and y_valid latencies of 1-5 cycles -> x_o stable under stall, result identical to REQ-035.
REQ-038 SHALL cover: rst_n pulsed low at vector 7 -> all outputs 0 asynchronously, IDLE; a later start gives pass=1.
REQ-039 SHALL cover: spurious y_valid in IDLE, then a check with the ideal DUT -> protocol_err=1 before start is cleared by start; a spurious y_valid during SEND gives pass=0.
REQ-040 SHALL cover: MIRROR_CHK_STOP_ON_FAIL_EN defined with the DUT of REQ-036 -> done at vector 4, fail_count=1.
